// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and bus layout for the fetch prefetch queue.
// The decode-facing bus is {adef, inst, pc}, MSB first.
package fetch_prefetch_queue_pkg;

  localparam int unsigned FQ_BUS_WD   = 65;
  localparam int unsigned FQ_PC_LSB   = 0;
  localparam int unsigned FQ_INST_LSB = 32;
  localparam int unsigned FQ_ADEF_BIT = 64;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  function automatic logic fq_pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_entry_fifo.sv
// Slot storage for the prefetch queue: reserve at tail, fill oldest pending, pop at head.
// Slots may be reserved already filled (address-error entries).
module fetch_entry_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      reserve,
  input  logic                      reserve_filled,
  input  fq_entry_t                 reserve_entry,
  input  logic                      fill,
  input  logic [31:0]               fill_inst,
  input  logic                      pop,
  output fq_entry_t                 head_entry,
  output logic                      head_filled,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t         slots [QDEPTH];
  logic [QDEPTH-1:0] filled;
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic [PW-1:0]     fill_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      filled   <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      filled   <= '0;
    end else begin
      if (pop) begin
        filled[head_ptr] <= 1'b0;
        head_ptr         <= head_ptr + PW'(1);
      end
      if (reserve) begin
        filled[tail_ptr] <= reserve_filled;
        tail_ptr         <= tail_ptr + PW'(1);
      end
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
      end
      // A pre-filled reservation never has pending slots ahead of it.
      if (fill || (reserve && reserve_filled)) begin
        fill_ptr <= fill_ptr + PW'(1);
      end
      count <= count + CW'(reserve) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reserve && !flush) begin
      slots[tail_ptr] <= reserve_entry;
    end
    if (fill && !flush) begin
      slots[fill_ptr].inst <= fill_inst;
    end
  end

  assign head_entry  = slots[head_ptr];
  assign head_filled = filled[head_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue between the SRAM-like fetch bus and decode.
// Tracks outstanding requests and discards responses made stale by redirects.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 inst_sram_req,
  output logic                 inst_sram_wr,
  output logic [1:0]           inst_sram_size,
  output logic [3:0]           inst_sram_wstrb,
  output logic [31:0]          inst_sram_addr,
  output logic [31:0]          inst_sram_wdata,
  input  logic                 inst_sram_addr_ok,
  input  logic                 inst_sram_data_ok,
  input  logic [31:0]          inst_sram_rdata,
  input  logic                 dec_allowin,
  output logic                 fetch_to_dec_valid,
  output logic [FQ_BUS_WD-1:0] fetch_to_dec_bus
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic [31:0]   npc;
  logic [OW-1:0] inflight;
  logic [OW-1:0] inflight_next;
  logic [OW-1:0] cancel_cnt;
  logic          halt;

  logic [CW-1:0] count;
  fq_entry_t     head_entry;
  fq_entry_t     rsv_entry;
  logic          head_filled;
  logic          has_space;
  logic          accept;
  logic          adef_enq;
  logic          rsp_live;
  logic          pop;

  // Occupancy is the pre-pop count so that full never depends on decode.
  assign has_space = count < CW'(QDEPTH);

  assign inst_sram_req = !reset && has_space && (inflight < OW'(MAX_OUTST)) &&
                         fq_pc_aligned(npc) && !halt;
  assign accept        = inst_sram_req && inst_sram_addr_ok;
  assign adef_enq      = !reset && !redirect_valid && has_space && !fq_pc_aligned(npc) && !halt;
  assign rsp_live      = inst_sram_data_ok && (cancel_cnt == '0) && !redirect_valid;
  assign inflight_next = inflight + OW'(accept) - OW'(inst_sram_data_ok);

  assign fetch_to_dec_valid = head_filled && !redirect_valid;
  assign pop                = fetch_to_dec_valid && dec_allowin;

  always_comb begin
    rsv_entry      = '0;
    rsv_entry.pc   = npc;
    rsv_entry.adef = adef_enq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      npc        <= RESET_PC;
      inflight   <= '0;
      cancel_cnt <= '0;
      halt       <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still on the bus after this cycle belongs to the old path.
        npc        <= redirect_pc;
        halt       <= 1'b0;
        cancel_cnt <= inflight_next;
      end else begin
        if (accept) begin
          npc <= npc + 32'd4;
        end
        if (adef_enq) begin
          halt <= 1'b1;
        end
        if (inst_sram_data_ok && (cancel_cnt != '0)) begin
          cancel_cnt <= cancel_cnt - OW'(1);
        end
      end
    end
  end

  fetch_entry_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .flush         (redirect_valid),
    .reserve       ((accept || adef_enq) && !redirect_valid),
    .reserve_filled(adef_enq),
    .reserve_entry (rsv_entry),
    .fill          (rsp_live),
    .fill_inst     (inst_sram_rdata),
    .pop           (pop),
    .head_entry    (head_entry),
    .head_filled   (head_filled),
    .count         (count)
  );

  assign inst_sram_addr  = npc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'd0;

  assign fetch_to_dec_bus[FQ_ADEF_BIT]                = head_entry.adef;
  assign fetch_to_dec_bus[FQ_INST_LSB +: 32]          = head_entry.inst;
  assign fetch_to_dec_bus[FQ_PC_LSB +: 32]            = head_entry.pc;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: two instances (4/2 and 8/1) driven by an in-order bus model,
// checked against the expected fetch stream derived from reset and redirect targets.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        redirect_valid [2];
  logic [31:0] redirect_pc    [2];
  logic        req            [2];
  logic        wr             [2];
  logic [1:0]  size           [2];
  logic [3:0]  wstrb          [2];
  logic [31:0] addr           [2];
  logic [31:0] wdata          [2];
  logic        addr_ok        [2];
  logic        data_ok        [2];
  logic [31:0] rdata          [2];
  logic        allowin        [2];
  logic        valid          [2];
  logic [64:0] bus            [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int unsigned lat [2];
  int unsigned aok_pct [2];
  int unsigned dok_pct [2];
  int          outst [2];
  int          held  [2];
  int          pops  [2];
  logic [31:0] exp_req [2];
  logic [31:0] exp_del [2];
  bit          del_done [2];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned QD = (g == 0) ? 4 : 8;
    localparam int unsigned MO = (g == 0) ? 2 : 1;

    logic [31:0] q_addr [$];
    int          q_due  [$];
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [64:0] exp_bus;

    fetch_prefetch_queue #(
      .QDEPTH   (QD),
      .MAX_OUTST(MO),
      .RESET_PC (RPC)
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .redirect_valid    (redirect_valid[g]),
      .redirect_pc       (redirect_pc[g]),
      .inst_sram_req     (req[g]),
      .inst_sram_wr      (wr[g]),
      .inst_sram_size    (size[g]),
      .inst_sram_wstrb   (wstrb[g]),
      .inst_sram_addr    (addr[g]),
      .inst_sram_wdata   (wdata[g]),
      .inst_sram_addr_ok (addr_ok[g]),
      .inst_sram_data_ok (data_ok[g]),
      .inst_sram_rdata   (rdata[g]),
      .dec_allowin       (allowin[g]),
      .fetch_to_dec_valid(valid[g]),
      .fetch_to_dec_bus  (bus[g])
    );

    // In-order slave: responds lat cycles after acceptance when the random gate allows.
    always @(posedge clk) begin
      #1;
      if (reset || q_addr.size() == 0) begin
        data_ok[g] = 1'b0;
        rdata[g]   = '0;
      end else begin
        data_ok[g] = (q_due[0] <= cyc) && ($urandom_range(99) < dok_pct[g]);
        rdata[g]   = inst_of(q_addr[0]);
      end
      addr_ok[g] = $urandom_range(99) < aok_pct[g];
    end

    always @(negedge clk) begin
      if (reset) begin
        q_addr.delete();
        q_due.delete();
        exp_req[g]  = RPC;
        exp_del[g]  = RPC;
        del_done[g] = 1'b0;
        held[g]     = 0;
        prev_wait   = 1'b0;
      end else begin
        checks++;
        if (q_addr.size() > MO) begin
          failures++;
          $display("FAIL inflight inst%0d got=%0d max=%0d", g, q_addr.size(), MO);
        end
        checks++;
        if ({wr[g], size[g], wstrb[g], wdata[g]} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
          failures++;
          $display("FAIL tieoff inst%0d got=%b/%b/%b/%h exp=0/10/0000/0", g, wr[g], size[g],
                   wstrb[g], wdata[g]);
        end
        if (prev_wait) begin
          checks++;
          if (!(req[g] === 1'b1 && addr[g] === prev_addr)) begin
            failures++;
            $display("FAIL req_hold inst%0d got req=%b addr=%h exp req=1 addr=%h", g, req[g],
                     addr[g], prev_addr);
          end
        end
        if (req[g]) begin
          checks++;
          if (exp_req[g][1:0] != 2'b00 || addr[g] !== exp_req[g]) begin
            failures++;
            $display("FAIL req_addr inst%0d got=%h exp=%h", g, addr[g], exp_req[g]);
          end
        end
        if (valid[g] && allowin[g]) begin
          checks++;
          pops[g]++;
          if (del_done[g]) begin
            failures++;
            $display("FAIL deliver_after_adef inst%0d got=%h exp=none", g, bus[g]);
          end else begin
            if (exp_del[g][1:0] != 2'b00) begin
              exp_bus     = {1'b1, 32'h0, exp_del[g]};
              del_done[g] = 1'b1;
            end else begin
              exp_bus = {1'b0, inst_of(exp_del[g]), exp_del[g]};
              exp_del[g] += 32'd4;
              held[g]--;
            end
            if (bus[g] !== exp_bus) begin
              failures++;
              $display("FAIL deliver inst%0d got=%h exp=%h", g, bus[g], exp_bus);
            end
          end
        end
        if (data_ok[g] && q_addr.size() > 0) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (req[g] && addr_ok[g]) begin
          q_addr.push_back(addr[g]);
          q_due.push_back(cyc + int'(lat[g]));
        end
        if (redirect_valid[g]) begin
          exp_req[g]  = redirect_pc[g];
          exp_del[g]  = redirect_pc[g];
          del_done[g] = 1'b0;
          held[g]     = 0;
        end else if (req[g] && addr_ok[g]) begin
          exp_req[g] += 32'd4;
          held[g]++;
        end
        prev_wait = req[g] && !addr_ok[g] && !redirect_valid[g];
        prev_addr = addr[g];
        outst[g]  = q_addr.size();
      end
    end
  end

  task automatic do_redirect(input int i, input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_valid[i] = 1'b1;
    redirect_pc[i]    = pc;
    @(posedge clk);
    #1;
    redirect_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      redirect_valid[i] = 1'b0;
      redirect_pc[i]    = '0;
      allowin[i]        = 1'b1;
      aok_pct[i]        = 100;
      dok_pct[i]        = 100;
      pops[i]           = 0;
    end
    lat[0] = 1;
    lat[1] = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req[i] !== 1'b0 || valid[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs inst%0d got req=%b valid=%b exp 0/0", i, req[i], valid[i]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req[i] !== 1'b1 || addr[i] !== RPC || valid[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release inst%0d got req=%b addr=%h valid=%b exp 1/%h/0", i, req[i],
                 addr[i], valid[i], RPC);
      end
    end
  endtask

  task automatic test_sequential();
    int p0;
    p0 = pops[0];
    repeat (30) @(negedge clk);
    checks++;
    if (pops[0] - p0 < 20) begin
      failures++;
      $display("FAIL seq_throughput got=%0d exp>=20", pops[0] - p0);
    end
  endtask

  task automatic test_stall(input int i, input int cycles, input int qd);
    int p0;
    @(posedge clk);
    #1;
    allowin[i] = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    checks++;
    if (held[i] != qd || req[i] !== 1'b0 || valid[i] !== 1'b1) begin
      failures++;
      $display("FAIL stall_full inst%0d got held=%0d req=%b valid=%b exp %0d/0/1", i, held[i],
               req[i], valid[i], qd);
    end
    @(posedge clk);
    #1;
    allowin[i] = 1'b1;
    p0 = pops[i];
    repeat (cycles) @(negedge clk);
    checks++;
    if (pops[i] - p0 < qd) begin
      failures++;
      $display("FAIL stall_drain inst%0d got=%0d exp>=%0d", i, pops[i] - p0, qd);
    end
  endtask

  task automatic wait_valid(input int i, input logic [64:0] expv, input string name);
    @(negedge clk);
    for (int k = 0; k < 60 && !valid[i]; k++) @(negedge clk);
    checks++;
    if (valid[i] !== 1'b1 || bus[i] !== expv) begin
      failures++;
      $display("FAIL %s inst%0d got valid=%b bus=%h exp 1/%h", name, i, valid[i], bus[i], expv);
    end
  endtask

  task automatic test_redirect_flush();
    lat[0] = 4;
    @(negedge clk);
    for (int k = 0; k < 40 && outst[0] < 2; k++) @(negedge clk);
    checks++;
    if (outst[0] != 2) begin
      failures++;
      $display("FAIL two_inflight got=%0d exp=2", outst[0]);
    end
    do_redirect(0, 32'h1c000100);
    wait_valid(0, {1'b0, inst_of(32'h1c000100), 32'h1c000100}, "redirect_first");
    repeat (20) @(negedge clk);
  endtask

  task automatic test_adef();
    do_redirect(0, 32'h1c000102);
    wait_valid(0, {1'b1, 32'h0, 32'h1c000102}, "adef_entry");
    repeat (10) @(negedge clk);
    checks++;
    if (valid[0] !== 1'b0 || req[0] !== 1'b0) begin
      failures++;
      $display("FAIL adef_halt got valid=%b req=%b exp 0/0", valid[0], req[0]);
    end
    lat[0] = 1;
    do_redirect(0, 32'h1c000200);
    wait_valid(0, {1'b0, inst_of(32'h1c000200), 32'h1c000200}, "adef_resume");
  endtask

  task automatic test_outst1_wrap();
    int p0;
    p0 = pops[1];
    repeat (80) @(negedge clk);
    checks++;
    if (pops[1] - p0 < 10) begin
      failures++;
      $display("FAIL outst1_rate got=%0d exp>=10", pops[1] - p0);
    end
    test_stall(1, 70, 8);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        redirect_valid[i] = 1'b0;
        allowin[i]        = $urandom_range(99) < 70;
        if ($urandom_range(99) < 4) begin
          pc = {4'h1, 12'($urandom), 14'($urandom), 2'b00};
          if ($urandom_range(3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
          redirect_valid[i] = 1'b1;
          redirect_pc[i]    = pc;
        end
        if (c % 50 == 0) begin
          lat[i]     = $urandom_range(1, (i == 0) ? 4 : 6);
          aok_pct[i] = $urandom_range(40, 100);
          dok_pct[i] = $urandom_range(40, 100);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      redirect_valid[i] = 1'b0;
      allowin[i]        = 1'b1;
      aok_pct[i]        = 100;
      dok_pct[i]        = 100;
    end
    do_redirect(0, 32'h1c001000);
    do_redirect(1, 32'h1c002000);
    checks++;
    if (pops[0] < 100 || pops[1] < 30) begin
      failures++;
      $display("FAIL random_progress got=%0d/%0d exp>=100/30", pops[0], pops[1]);
    end
  endtask

  task automatic test_reset_midburst();
    lat[0] = 1;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req[i] !== 1'b0 || valid[i] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset inst%0d got req=%b valid=%b exp 0/0", i, req[i], valid[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req[i] !== 1'b1 || addr[i] !== RPC) begin
        failures++;
        $display("FAIL post_reset_addr inst%0d got req=%b addr=%h exp 1/%h", i, req[i], addr[i],
                 RPC);
      end
    end
    wait_valid(0, {1'b0, inst_of(RPC), RPC}, "post_reset_first");
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall(0, 10, 4);
    test_redirect_flush();
    test_adef();
    test_outst1_wrap();
    test_random();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
